// File: rtl/bram_wr_pkg.sv
// Shared types and defaults for the BRAM burst write controller.
package bram_wr_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 12;
  localparam int MAX_LEN    = 4096;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_FINISH = 2'd2
  } state_t;

endpackage

// File: rtl/bram_wr_if.sv
// Burst request, stream input and BRAM write port bundle.
interface bram_wr_if
  import bram_wr_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) ();

  logic              START;
  logic [ADDR_W-1:0] BASE_ADDR;
  logic [ADDR_W:0]   LENGTH;
  logic              ABORT;
  logic [DATA_W-1:0] DIN;
  logic              DIN_VALID;
  logic              DIN_READY;
  logic [DATA_W-1:0] DI;
  logic [ADDR_W-1:0] WRADDR;
  logic              WREN;
  logic              WE;
  logic              BUSY;
  logic              DONE;
  logic              ABORTED;
  logic [ADDR_W:0]   WR_COUNT;

  modport slave (
    input  START, BASE_ADDR, LENGTH, ABORT, DIN, DIN_VALID,
    output DIN_READY, DI, WRADDR, WREN, WE, BUSY, DONE, ABORTED, WR_COUNT
  );

  modport master (
    output START, BASE_ADDR, LENGTH, ABORT, DIN, DIN_VALID,
    input  DIN_READY, DI, WRADDR, WREN, WE, BUSY, DONE, ABORTED, WR_COUNT
  );

endinterface

// File: rtl/bram_wr_addr_ctr.sv
// Write address and byte-count registers; the address wraps at the BRAM depth.
module bram_wr_addr_ctr
  import bram_wr_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              inc,
  input  logic [ADDR_W-1:0] load_addr,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   COUNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W:0]   count_r;

  // load on burst start, step once per accepted beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_r  <= {ADDR_W{1'b0}};
      count_r <= {(ADDR_W+1){1'b0}};
    end else if (load) begin
      addr_r  <= load_addr;
      count_r <= {(ADDR_W+1){1'b0}};
    end else if (inc) begin
      addr_r  <= addr_r + ADDR_ONE;
      count_r <= count_r + COUNT_ONE;
    end
  end

  assign addr  = addr_r;
  assign count = count_r;

endmodule

// File: rtl/bram_wr_ctrl.sv
// Streams a burst of bytes into a simple-dual-port BRAM write port,
// with abort, zero-length and over-length handling.
module bram_wr_ctrl
  import bram_wr_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input logic      WRCLK,
  input logic      RST,
  bram_wr_if.slave bus
);

  localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] LEN_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_r;
  state_t            state_s;
  logic              load_s;
  logic              inc_s;
  logic              done_s;
  logic              aborted_s;
  logic [ADDR_W:0]   len_in_s;
  logic [ADDR_W:0]   len_r;
  logic [ADDR_W:0]   count_s;
  logic [ADDR_W-1:0] addr_s;
  logic [DATA_W-1:0] di_r;
  logic [ADDR_W-1:0] wraddr_r;
  logic              wren_r;
  logic              busy_r;
  logic              done_r;
  logic              aborted_r;

  // Oversized requests are clamped to the full BRAM depth
  assign len_in_s      = (bus.LENGTH > LEN_MAX) ? LEN_MAX : bus.LENGTH;
  assign bus.DIN_READY = (state_r == ST_WRITE) && !bus.ABORT;

  bram_wr_addr_ctr #(.ADDR_W(ADDR_W)) u_addr_ctr (
    .clk       (WRCLK),
    .rst       (RST),
    .load      (load_s),
    .inc       (inc_s),
    .load_addr (bus.BASE_ADDR),
    .addr      (addr_s),
    .count     (count_s)
  );

  // state register
  always_ff @(posedge WRCLK or posedge RST) begin
    if (RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // next-state and per-cycle control decode; ABORT outranks a pending beat
  always_comb begin
    state_s   = state_r;
    load_s    = 1'b0;
    inc_s     = 1'b0;
    done_s    = 1'b0;
    aborted_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (bus.START) begin
          load_s = 1'b1;
          if (len_in_s == {(ADDR_W+1){1'b0}}) begin
            done_s = 1'b1;
          end else begin
            state_s = ST_WRITE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WRITE: begin
        if (bus.ABORT) begin
          aborted_s = 1'b1;
          state_s   = ST_IDLE;
        end else if (bus.DIN_VALID) begin
          inc_s = 1'b1;
          if ((count_s + LEN_ONE) == len_r) begin
            state_s = ST_FINISH;
          end else begin
            state_s = ST_WRITE;
          end
        end else begin
          state_s = ST_WRITE;
        end
      end
      ST_FINISH: begin
        done_s  = 1'b1;
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // registered BRAM port and status outputs; data/address hold between strobes
  always_ff @(posedge WRCLK or posedge RST) begin
    if (RST) begin
      len_r     <= {(ADDR_W+1){1'b0}};
      di_r      <= {DATA_W{1'b0}};
      wraddr_r  <= {ADDR_W{1'b0}};
      wren_r    <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      aborted_r <= 1'b0;
    end else begin
      if (load_s) begin
        len_r <= len_in_s;
      end
      if (inc_s) begin
        di_r     <= bus.DIN;
        wraddr_r <= addr_s;
      end
      wren_r    <= inc_s;
      busy_r    <= (state_s != ST_IDLE);
      done_r    <= done_s;
      aborted_r <= aborted_s;
    end
  end

  assign bus.DI       = di_r;
  assign bus.WRADDR   = wraddr_r;
  assign bus.WREN     = wren_r;
  assign bus.WE       = wren_r;
  assign bus.BUSY     = busy_r;
  assign bus.DONE     = done_r;
  assign bus.ABORTED  = aborted_r;
  assign bus.WR_COUNT = count_s;

endmodule

// File: tb/tb_bram_wr_ctrl.sv
// Directed bench for bram_wr_ctrl: bursts, wrap, gaps, abort, reset, clamp.
module tb_bram_wr_ctrl;
  import bram_wr_pkg::*;

  logic WRCLK = 1'b0;
  logic RST;

  bram_wr_if #(.DATA_W(8), .ADDR_W(12)) bus ();

  bram_wr_ctrl #(.DATA_W(8), .ADDR_W(12)) dut (
    .WRCLK (WRCLK),
    .RST   (RST),
    .bus   (bus)
  );

  always #5 WRCLK = ~WRCLK;

  int n_pass  = 0;
  int n_total = 0;
  int wr_total   = 0;
  int done_total = 0;
  int ab_total   = 0;
  int we_bad     = 0;
  logic [19:0] wr_log [0:8191];

  // write/pulse recorder, sampled mid-cycle
  always @(negedge WRCLK) begin
    if (bus.WREN === 1'b1) begin
      if (wr_total < 8192) wr_log[13'(wr_total)] = {bus.WRADDR, bus.DI};
      wr_total++;
    end
    if (bus.WE !== bus.WREN) we_bad++;
    if (bus.DONE === 1'b1) done_total++;
    if (bus.ABORTED === 1'b1) ab_total++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge WRCLK);
    #1;
  endtask

  function automatic logic [7:0] dat(input int k);
    return 8'(k) ^ 8'h5A;
  endfunction

  task automatic start(input logic [11:0] base, input logic [12:0] len);
    bus.START     = 1'b1;
    bus.BASE_ADDR = base;
    bus.LENGTH    = len;
    tick();
    bus.START = 1'b0;
  endtask

  task automatic check_log(input string tag, input int first, input int n, input logic [11:0] base);
    int bad;
    logic [11:0] a;
    bad = 0;
    chk({tag, "_nwr"}, 32'(wr_total - first), 32'(n));
    for (int i = 0; i < n; i++) begin
      a = base + 12'(i);
      if (first + i >= 8192) bad++;
      else if (wr_log[13'(first + i)] !== {a, dat(i)}) bad++;
    end
    chk({tag, "_data"}, 32'(bad), 32'd0);
  endtask

  task automatic run_stream(input string tag, input logic [11:0] base, input logic [12:0] len,
                            input int n_exp, input int off);
    int first, d0, k, cyc, ph;
    logic v;
    first = wr_total; d0 = done_total; k = 0; cyc = 0; ph = 0;
    start(base, len);
    while (done_total == d0 && cyc < 6000) begin
      v  = (ph == 0);
      ph = (ph == off) ? 0 : ph + 1;
      bus.DIN       = dat(k);
      bus.DIN_VALID = v;
      #1;
      if (v && bus.DIN_READY) k++;
      tick();
      cyc++;
    end
    bus.DIN_VALID = 1'b0;
    repeat (3) tick();
    chk({tag, "_timeout"}, 32'(cyc < 6000), 32'd1);
    check_log(tag, first, n_exp, base);
    chk({tag, "_done"}, 32'(done_total - d0), 32'd1);
    chk({tag, "_cnt"}, 32'(bus.WR_COUNT), 32'(n_exp));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int first, d0, a0, n_w;
    RST = 1'b1;
    bus.START = 1'b0; bus.BASE_ADDR = 12'h000; bus.LENGTH = 13'd0;
    bus.ABORT = 1'b0; bus.DIN = 8'h00; bus.DIN_VALID = 1'b0;
    #12;
    chk("rst_data", 32'({bus.DI, bus.WRADDR}), 32'd0);
    chk("rst_ctl", 32'({bus.WREN, bus.WE, bus.BUSY, bus.DONE, bus.ABORTED, bus.DIN_READY, bus.WR_COUNT}), 32'd0);

    // Scenario 1: first START right after reset release, back-to-back beats
    tick();
    RST = 1'b0;
    start(12'h010, 13'd4);
    chk("s1_busy", 32'(bus.BUSY), 32'd1);
    chk("s1_cnt0", 32'(bus.WR_COUNT), 32'd0);
    for (int i = 0; i < 4; i++) begin
      bus.DIN = 8'(8'hA1 + i);
      bus.DIN_VALID = 1'b1;
      #1;
      chk("s1_rdy", 32'(bus.DIN_READY), 32'd1);
      tick();
      chk("s1_wren", 32'({bus.WREN, bus.WE}), 32'd3);
      chk("s1_addr", 32'(bus.WRADDR), 32'(12'h010 + i));
      chk("s1_di", 32'(bus.DI), 32'(8'hA1 + i));
      chk("s1_cnt", 32'(bus.WR_COUNT), 32'(i + 1));
    end
    bus.DIN_VALID = 1'b0;
    #1;
    chk("s1_rdy_fin", 32'(bus.DIN_READY), 32'd0);
    tick();
    chk("s1_done", 32'({bus.DONE, bus.WREN, bus.BUSY}), 32'd4);
    chk("s1_hold", 32'({bus.WRADDR, bus.DI}), 32'h013A4);
    tick();
    chk("s1_done_end", 32'(bus.DONE), 32'd0);

    // Scenario 2 and 3: address wrap, gapped valid
    run_stream("s2", 12'hFFE, 13'd4, 4, 0);
    run_stream("s3", 12'h040, 13'd3, 3, 2);

    // Scenario 4: abort after 2 of 8, ABORT and VALID together
    first = wr_total; d0 = done_total; a0 = ab_total;
    start(12'h100, 13'd8);
    for (int k = 0; k < 2; k++) begin
      bus.DIN = dat(k); bus.DIN_VALID = 1'b1;
      tick();
    end
    bus.DIN = dat(2); bus.ABORT = 1'b1;
    #1;
    chk("s4_rdy", 32'(bus.DIN_READY), 32'd0);
    tick();
    chk("s4_ab", 32'({bus.ABORTED, bus.BUSY, bus.WREN}), 32'd4);
    chk("s4_cnt", 32'(bus.WR_COUNT), 32'd2);
    bus.ABORT = 1'b0; bus.DIN_VALID = 1'b0;
    tick();
    chk("s4_ab_end", 32'(bus.ABORTED), 32'd0);
    repeat (2) tick();
    check_log("s4", first, 2, 12'h100);
    chk("s4_nodone", 32'(done_total - d0), 32'd0);
    chk("s4_abcnt", 32'(ab_total - a0), 32'd1);

    // Scenario 4b: ABORT coincides with the final beat
    first = wr_total; d0 = done_total; a0 = ab_total;
    start(12'h180, 13'd2);
    bus.DIN = dat(0); bus.DIN_VALID = 1'b1;
    tick();
    bus.DIN = dat(1); bus.ABORT = 1'b1;
    tick();
    chk("s4b_ab", 32'({bus.ABORTED, bus.DONE, bus.WREN}), 32'd4);
    chk("s4b_cnt", 32'(bus.WR_COUNT), 32'd1);
    bus.ABORT = 1'b0; bus.DIN_VALID = 1'b0;
    repeat (3) tick();
    check_log("s4b", first, 1, 12'h180);
    chk("s4b_nodone", 32'(done_total - d0), 32'd0);
    chk("s4b_abcnt", 32'(ab_total - a0), 32'd1);

    // Scenario 5: reset mid-burst, then zero-length START
    start(12'h200, 13'd8);
    for (int k = 0; k < 3; k++) begin
      bus.DIN = dat(k); bus.DIN_VALID = 1'b1;
      tick();
    end
    RST = 1'b1;
    #1;
    chk("s5_rst_data", 32'({bus.DI, bus.WRADDR}), 32'd0);
    chk("s5_rst_ctl", 32'({bus.WREN, bus.WE, bus.BUSY, bus.DONE, bus.ABORTED, bus.DIN_READY, bus.WR_COUNT}), 32'd0);
    bus.DIN_VALID = 1'b0;
    n_w = wr_total; d0 = done_total; a0 = ab_total;
    repeat (2) tick();
    RST = 1'b0;
    start(12'h555, 13'd0);
    chk("s5_len0", 32'({bus.DONE, bus.BUSY, bus.WREN}), 32'd4);
    tick();
    chk("s5_len0_end", 32'(bus.DONE), 32'd0);
    repeat (2) tick();
    chk("s5_nowr", 32'(wr_total - n_w), 32'd0);
    chk("s5_ndone", 32'(done_total - d0), 32'd1);
    chk("s5_noab", 32'(ab_total - a0), 32'd0);

    // Scenario 5b: START while busy is ignored
    first = wr_total; d0 = done_total;
    start(12'h300, 13'd2);
    bus.DIN = dat(0); bus.DIN_VALID = 1'b1;
    bus.START = 1'b1; bus.BASE_ADDR = 12'h007; bus.LENGTH = 13'd1;
    tick();
    bus.START = 1'b0; bus.DIN = dat(1);
    tick();
    bus.DIN_VALID = 1'b0;
    repeat (3) tick();
    check_log("s5b", first, 2, 12'h300);
    chk("s5b_cnt", 32'(bus.WR_COUNT), 32'd2);
    chk("s5b_done", 32'(done_total - d0), 32'd1);

    // Scenario 6: over-length request clamped to full depth
    run_stream("s6", 12'h123, 13'd5000, 4096, 0);

    chk("we_eq_wren", 32'(we_bad), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/bram_wr_ctrl.md
BRAM_WR_CTRL -- requirements
Module: bram_wr_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8: write data width, matching the 8-bit simple-dual-port BRAM write port.
REQ-002 SHALL have parameter ADDR_W, default 12: BRAM address width, giving a depth of 4096.
REQ-003 SHALL use one clock; reset SHALL be asynchronous and active-high. Ports are as follows.
REQ-004 SHALL have port WRCLK, input, 1: the sole clock; all logic is on its rising edge.
REQ-005 SHALL have port RST, input, 1: asynchronous active-high reset.
REQ-006 SHALL have port START, input, 1: single-cycle request to begin a burst.
REQ-007 SHALL have port BASE_ADDR, input, ADDR_W: first write address, sampled on START.
REQ-008 SHALL have port LENGTH, input, ADDR_W+1: number of bytes in the burst, sampled on START.
REQ-009 SHALL have port ABORT, input, 1: terminates an active burst.
REQ-010 SHALL have port DIN, input, DATA_W: stream data.
REQ-011 SHALL have port DIN_VALID, input, 1: stream data valid.
REQ-012 SHALL have port DIN_READY, output, 1: the block accepts a beat when DIN_VALID && DIN_READY.
REQ-013 SHALL have port DI, output, DATA_W: BRAM write data.
REQ-014 SHALL have port WRADDR, output, ADDR_W: BRAM write address.
REQ-015 SHALL have port WREN, output, 1: BRAM write port enable.
REQ-016 SHALL have port WE, output, 1: BRAM write enable.
REQ-017 SHALL have port BUSY, output, 1: high whenever the state is not IDLE.
REQ-018 SHALL have port DONE, output, 1: one-cycle pulse when a burst completes normally.
REQ-019 SHALL have port ABORTED, output, 1: one-cycle pulse when a burst ends by ABORT.
REQ-020 SHALL have port WR_COUNT, output, ADDR_W+1: number of bytes written in the current or last burst.

Function
REQ-021 SHALL implement the states IDLE, WRITE and FINISH.
REQ-022 In IDLE, START with LENGTH 1..4096 SHALL, on that edge, latch the base address and length, clear WR_COUNT, and go to WRITE.
REQ-023 In IDLE, START with LENGTH=0 SHALL produce no writes and pulse DONE in the next cycle; a LENGTH above 4096 SHALL be clamped to 4096.
REQ-024 START SHALL be ignored in WRITE and FINISH.
REQ-025 DIN_READY SHALL be asserted only when the state is WRITE and ABORT=0.
REQ-026 Each accepted beat SHALL, on the next clock, drive WREN=WE=1 for exactly one cycle, with DI=DIN and WRADDR=current address; this is 1-cycle latency.
REQ-027 After each beat the address SHALL increment modulo 4096 (4095 wraps to 0) and WR_COUNT SHALL increment by 1.
REQ-028 Accepting the beat that makes WR_COUNT equal LENGTH SHALL move the state to FINISH; DIN_READY SHALL be low from the next cycle.
REQ-029 FINISH SHALL last one cycle, in which the final write strobe is visible, then go to IDLE with DONE=1 for that one cycle.
REQ-030 ABORT in WRITE SHALL go to IDLE on the next edge and pulse ABORTED; no beat SHALL be accepted in the ABORT cycle, and WR_COUNT SHALL hold.
REQ-031 If ABORT arrives in the same cycle as the final beat, ABORT SHALL win: the beat is not accepted and ABORTED pulses instead of DONE.
REQ-032 When WREN=0, DI and WRADDR SHALL hold their last values.
REQ-033 DIN_VALID=0 in WRITE SHALL stall the burst indefinitely with no timeout.
REQ-034 All outputs except DIN_READY SHALL be registered; DIN_READY SHALL be decoded combinationally from state and ABORT.

Reset
REQ-035 RST SHALL asynchronously force state IDLE and set every output to 0, including DI, WRADDR and WR_COUNT.
REQ-036 RST asserted mid-burst SHALL discard the burst: no DONE, no ABORTED, and no further WREN.
REQ-037 After RST deasserts, the first START SHALL be honoured on the first clock edge.

Structure
REQ-038 Package bram_wr_pkg SHALL hold the state enum, the DATA_W and ADDR_W defaults, and MAX_LEN=4096.
REQ-039 Sub-module bram_wr_addr_ctr SHALL provide the load/increment address and count registers with modulo-4096 wrap.

Verification
REQ-040 Scenario 1: BASE=0x010, LENGTH=4, bytes A1..A4 streamed back-to-back -> WREN on 4 consecutive cycles at addresses 0x010..0x013, DONE one cycle after the last WREN, WR_COUNT=4.
REQ-041 Scenario 2: BASE=0xFFE, LENGTH=4 -> writes to 0xFFE, 0xFFF, 0x000, 0x001.
REQ-042 Scenario 3: LENGTH=3 with DIN_VALID gapped 1-on/2-off -> exactly 3 WREN pulses, no duplicates, DONE once.
REQ-043 Scenario 4: ABORT after 2 of 8 beats, including a case with ABORT and VALID in the same cycle -> WR_COUNT=2, ABORTED pulses, DONE never asserts, DIN_READY is 0 in the ABORT cycle.
REQ-044 Scenario 5: RST mid-burst, then START with LENGTH=0 -> all outputs 0 while in reset, then DONE pulses with no WREN; a START issued while BUSY is ignored.
REQ-045 Scenario 6: LENGTH=5000 -> exactly 4096 writes, then DONE.
